gpio_input_conditioner: RTL and testbench
=========================================

# gpio_input_conditioner

Parametrised input front end for the board's raw switches and buttons, sitting between the top-level pins and the MicroBlaze GPIO inputs. Each of N_CH channels is synchronised, optionally inverted for active-low sources, and debounced, with rise/fall edge pulses generated per channel. Selected edges are captured into a sticky event register with per-bit clear and an interrupt output. Software thus sees clean levels and latched events instead of sampling bouncing pins.

## Interface
- N_CH, 20: channel count (16 switches + 4 buttons).
- SYNC_STAGES, 2: synchroniser depth, ≥2.
- DB_CYCLES, 1000000: debounce window in clk cycles, ≥1 (10 ms at 100 MHz).
- INVERT_MASK, 0: per-channel inversion applied after synchronisation; 1 = active-low source.
- RISE_MASK, all 1: per-channel enable for capturing rising edges into event_q.
- FALL_MASK, all 0: per-channel enable for capturing falling edges into event_q.

- clk  in  1  system clock, 100 MHz.
- reset_rtl_0  in  1  synchronous reset, active-high.
- raw_in  in  N_CH  asynchronous pin inputs.
- level_out  out  N_CH  debounced, polarity-corrected level.
- rise_pulse  out  N_CH  one-cycle pulse when level_out goes 0→1.
- fall_pulse  out  N_CH  one-cycle pulse when level_out goes 1→0.
- event_q  out  N_CH  sticky captured-edge flags.
- clr_valid  in  1  clear strobe, sampled every cycle.
- clr_mask  in  N_CH  bits of event_q to clear when clr_valid=1.
- irq_en  in  N_CH  per-channel interrupt enable.
- irq  out  1  registered OR of (event_q & irq_en).

## Operation
- Reset values:
  - Synchroniser flops load INVERT_MASK, so the post-inversion value is 0.
  - Debounce counters = 0.
  - level_out = 0, rise_pulse = 0, fall_pulse = 0.
  - event_q = 0, irq = 0.
- Per channel, sync = last synchroniser stage XOR INVERT_MASK bit.
- Debounce counter:
  - Width is $clog2(DB_CYCLES), minimum 1.
  - If sync == level_out, the counter clears to 0.
  - Otherwise, if the counter == DB_CYCLES-1, level_out toggles and the counter clears.
  - Otherwise, the counter increments.
  - A glitch shorter than DB_CYCLES cycles never reaches level_out.
  - The counter never exceeds DB_CYCLES-1, so there is no wrap.
- Edge pulses: rise_pulse and fall_pulse are registered and asserted in the same cycle level_out takes its new value. They are mutually exclusive and last exactly 1 cycle.
- Event capture: set_vec = (rise_pulse & RISE_MASK) | (fall_pulse & FALL_MASK).
- Event register update: event_q <= (event_q & ~(clr_valid ? clr_mask : 0)) | set_vec.
  - Set wins over a simultaneous clear of the same bit.
  - Clearing bits with no pending event has no effect.
- irq <= |(event_q & irq_en).
  - irq deasserts 1 cycle after the last enabled bit clears.
  - Changing irq_en takes effect on the next edge.
- Channels are fully independent; any number of them may change in the same cycle.
- Reset asserted mid-debounce discards partial counts and pending events. After release, a channel held high re-debounces from 0 and produces a rise_pulse.

## Timing
- Pin to sync latency: SYNC_STAGES edges.
- Raw to level_out latency: level_out changes on edge SYNC_STAGES + DB_CYCLES, counting from the first edge that samples the new raw value (edge 1), provided raw stays stable.
- rise_pulse / fall_pulse: same edge as the level_out change.
- event_q: sets 1 edge after the pulse.
- irq: asserts 1 edge after event_q, i.e. edge SYNC_STAGES + DB_CYCLES + 2 from edge 1.
- Clear: clr_valid at edge k clears event_q at edge k. irq falls at edge k+1 if no other enabled bit is set.
- No backpressure or handshake beyond the clr_valid strobe; clr_valid may be held high continuously.

## Test plan
- Reset and settle (SYNC_STAGES=2, DB_CYCLES=4, all raw_in=0): after reset, all outputs are 0 for 20 cycles; no pulses or irq.
- Clean press (ch0 raw 0→1, held): level_out[0]=1 and rise_pulse[0]=1 (for 1 cycle) at edge 6 from first sample. event_q[0]=1 at edge 7; irq=1 at edge 8 with irq_en[0]=1.
- Bounce rejection (ch1 raw high for 3 cycles, low 1, high 3, low): level_out[1] stays 0; no pulses; event_q unchanged.
- Active-low button (INVERT_MASK[16]=1, raw_in[16] held 1 then driven 0):
  - No event after reset.
  - After the press, level_out[16]=1 and event_q[16]=1.
  - On release, fall_pulse[16] fires, but event_q is not set again because FALL_MASK=0.
- Simultaneous set and clear (event_q[2]=1, clr_valid=1 with clr_mask[2]=1 on the same edge as a new rise_pulse[2]): event_q[2] stays 1. A clear on the next cycle with no pulse takes event_q[2] to 0, and irq falls 1 cycle later.
- Reset mid-debounce (ch3 raw high for 3 cycles, reset_rtl_0 pulsed for 1 cycle, raw held high): no pulse before reset; level_out[3]=1 exactly 6 edges after reset release.

Source files
------------

// File: rtl/gpio_input_conditioner_if.sv
// Pin-side and software-side signal bundle of the GPIO input conditioner.
// The master drives pins and clear/enable controls; the slave is the conditioner.
interface gpio_input_conditioner_if #(
    parameter int N_CH = 20
);
    logic [N_CH-1:0] raw_in;
    logic [N_CH-1:0] level_out;
    logic [N_CH-1:0] rise_pulse;
    logic [N_CH-1:0] fall_pulse;
    logic [N_CH-1:0] event_q;
    logic            clr_valid;
    logic [N_CH-1:0] clr_mask;
    logic [N_CH-1:0] irq_en;
    logic            irq;

    modport master (
        output raw_in,
        output clr_valid,
        output clr_mask,
        output irq_en,
        input  level_out,
        input  rise_pulse,
        input  fall_pulse,
        input  event_q,
        input  irq
    );

    modport slave (
        input  raw_in,
        input  clr_valid,
        input  clr_mask,
        input  irq_en,
        output level_out,
        output rise_pulse,
        output fall_pulse,
        output event_q,
        output irq
    );
endinterface

// File: rtl/gpio_input_conditioner.sv
// Per-channel synchroniser, polarity fix, debounce and edge detection for raw
// switch/button pins, with sticky edge events and a level interrupt.
module gpio_input_conditioner #(
    parameter int              N_CH        = 20,
    parameter int              SYNC_STAGES = 2,
    parameter int              DB_CYCLES   = 1000000,
    parameter logic [N_CH-1:0] INVERT_MASK = {N_CH{1'b0}},
    parameter logic [N_CH-1:0] RISE_MASK   = {N_CH{1'b1}},
    parameter logic [N_CH-1:0] FALL_MASK   = {N_CH{1'b0}}
) (
    input logic                     clk,
    input logic                     reset_rtl_0,
    gpio_input_conditioner_if.slave bus
);

    localparam int              CNT_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [N_CH-1:0]  sync_r [SYNC_STAGES];
    logic [N_CH-1:0]  sync_s;
    logic [CNT_W-1:0] cnt_r      [N_CH];
    logic [CNT_W-1:0] cnt_nxt_s  [N_CH];
    logic [N_CH-1:0]  level_r;
    logic [N_CH-1:0]  level_nxt_s;
    logic [N_CH-1:0]  rise_r;
    logic [N_CH-1:0]  fall_r;
    logic [N_CH-1:0]  rise_nxt_s;
    logic [N_CH-1:0]  fall_nxt_s;
    logic [N_CH-1:0]  set_vec_s;
    logic [N_CH-1:0]  clr_vec_s;
    logic [N_CH-1:0]  event_r;
    logic [N_CH-1:0]  event_nxt_s;
    logic             irq_r;

    // Synchroniser chain; reset loads the inversion mask so the corrected level starts at 0
    always_ff @(posedge clk) begin
        if (reset_rtl_0) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_r[s] <= INVERT_MASK;
            end
        end else begin
            sync_r[0] <= bus.raw_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_r[s] <= sync_r[s-1];
            end
        end
    end

    assign sync_s = sync_r[SYNC_STAGES-1] ^ INVERT_MASK;

    // Debounce: a channel must disagree with level_out for DB_CYCLES consecutive cycles to flip
    always_comb begin
        level_nxt_s = level_r;
        for (int c = 0; c < N_CH; c++) begin
            cnt_nxt_s[c] = cnt_r[c];
            if (sync_s[c] == level_r[c]) begin
                cnt_nxt_s[c] = CNT_ZERO;
            end else if (cnt_r[c] == CNT_MAX) begin
                cnt_nxt_s[c]   = CNT_ZERO;
                level_nxt_s[c] = ~level_r[c];
            end else begin
                cnt_nxt_s[c] = cnt_r[c] + CNT_ONE;
            end
        end
        rise_nxt_s = level_nxt_s & ~level_r;
        fall_nxt_s = ~level_nxt_s & level_r;
    end

    // Debounce state, level and edge pulse registers
    always_ff @(posedge clk) begin
        if (reset_rtl_0) begin
            for (int c = 0; c < N_CH; c++) begin
                cnt_r[c] <= CNT_ZERO;
            end
            level_r <= {N_CH{1'b0}};
            rise_r  <= {N_CH{1'b0}};
            fall_r  <= {N_CH{1'b0}};
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                cnt_r[c] <= cnt_nxt_s[c];
            end
            level_r <= level_nxt_s;
            rise_r  <= rise_nxt_s;
            fall_r  <= fall_nxt_s;
        end
    end

    // Event capture: OR-ing the set vector after the clear makes a new edge win over a clear
    always_comb begin
        set_vec_s = (rise_r & RISE_MASK) | (fall_r & FALL_MASK);
        if (bus.clr_valid) begin
            clr_vec_s = bus.clr_mask;
        end else begin
            clr_vec_s = {N_CH{1'b0}};
        end
        event_nxt_s = (event_r & ~clr_vec_s) | set_vec_s;
    end

    // Sticky event register and interrupt, the latter one cycle behind event_q
    always_ff @(posedge clk) begin
        if (reset_rtl_0) begin
            event_r <= {N_CH{1'b0}};
            irq_r   <= 1'b0;
        end else begin
            event_r <= event_nxt_s;
            irq_r   <= |(event_r & bus.irq_en);
        end
    end

    assign bus.level_out  = level_r;
    assign bus.rise_pulse = rise_r;
    assign bus.fall_pulse = fall_r;
    assign bus.event_q    = event_r;
    assign bus.irq        = irq_r;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Directed bench for gpio_input_conditioner: a table of per-cycle vectors plus
// hand-written sequences for set/clear collision and reset mid-debounce.
module tb_gpio_input_conditioner;

    localparam int         N    = 20;
    localparam logic [N-1:0] IDLE = 20'h10000;  // ch16 is an active-low button, idle high

    typedef struct {
        logic [N-1:0] raw;
        logic         clrv;
        logic [N-1:0] clrm;
        logic [N-1:0] en;
        logic [N-1:0] lvl;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
        logic [N-1:0] ev;
        logic         irq;
    } vec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    vec_t vecs[$];

    gpio_input_conditioner_if #(.N_CH(N)) bus_if ();

    gpio_input_conditioner #(
        .N_CH        (N),
        .SYNC_STAGES (2),
        .DB_CYCLES   (4),
        .INVERT_MASK (20'h10000),
        .RISE_MASK   (20'hFFFFF),
        .FALL_MASK   (20'h00000)
    ) dut (
        .clk         (clk),
        .reset_rtl_0 (rst),
        .bus         (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
        end
        #1;
    endtask

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [N-1:0] raw, input logic clrv, input logic [N-1:0] clrm,
                       input logic [N-1:0] en, input logic [N-1:0] lvl, input logic [N-1:0] rise,
                       input logic [N-1:0] fall, input logic [N-1:0] ev, input logic irq);
        vec_t v;
        v.raw = raw; v.clrv = clrv; v.clrm = clrm; v.en = en;
        v.lvl = lvl; v.rise = rise; v.fall = fall; v.ev = ev; v.irq = irq;
        vecs.push_back(v);
    endtask

    task automatic chk_all(input string tag, input logic [N-1:0] lvl, input logic [N-1:0] rise,
                           input logic [N-1:0] fall, input logic [N-1:0] ev, input logic irq);
        chk({tag, " level"}, bus_if.level_out, lvl);
        chk({tag, " rise"},  bus_if.rise_pulse, rise);
        chk({tag, " fall"},  bus_if.fall_pulse, fall);
        chk({tag, " event"}, bus_if.event_q, ev);
        chk({tag, " irq"},   {19'd0, bus_if.irq}, {19'd0, irq});
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // Clean press of ch0: level/rise on edge 6, event edge 7, irq edge 8, then clear
        for (int i = 0; i < 5; i++) add(20'h10001, 1'b0, 20'h0, 20'h1, 20'h0, 20'h0, 20'h0, 20'h0, 1'b0);
        add(20'h10001, 1'b0, 20'h0, 20'h1, 20'h1, 20'h1, 20'h0, 20'h0, 1'b0);
        add(20'h10001, 1'b0, 20'h0, 20'h1, 20'h1, 20'h0, 20'h0, 20'h1, 1'b0);
        add(20'h10001, 1'b0, 20'h0, 20'h1, 20'h1, 20'h0, 20'h0, 20'h1, 1'b1);
        add(20'h10001, 1'b0, 20'h0, 20'h1, 20'h1, 20'h0, 20'h0, 20'h1, 1'b1);
        add(20'h10001, 1'b1, 20'h1, 20'h1, 20'h1, 20'h0, 20'h0, 20'h0, 1'b1);
        add(20'h10001, 1'b0, 20'h0, 20'h1, 20'h1, 20'h0, 20'h0, 20'h0, 1'b0);
        // Bounce on ch1: H H H L H H H L L L never reaches level_out
        for (int i = 0; i < 10; i++) begin
            add((i == 3 || i >= 7) ? 20'h10001 : 20'h10003, 1'b0, 20'h0, 20'h1,
                20'h1, 20'h0, 20'h0, 20'h0, 1'b0);
        end
        // Active-low ch16 press, clear its event, then release: fall pulse but no new event
        for (int i = 0; i < 5; i++) add(20'h00001, 1'b0, 20'h0, 20'h1, 20'h00001, 20'h0, 20'h0, 20'h0, 1'b0);
        add(20'h00001, 1'b0, 20'h0, 20'h1, 20'h10001, 20'h10000, 20'h0, 20'h0, 1'b0);
        add(20'h00001, 1'b0, 20'h0, 20'h1, 20'h10001, 20'h0, 20'h0, 20'h10000, 1'b0);
        add(20'h00001, 1'b0, 20'h0, 20'h1, 20'h10001, 20'h0, 20'h0, 20'h10000, 1'b0);
        add(20'h00001, 1'b1, 20'h10000, 20'h1, 20'h10001, 20'h0, 20'h0, 20'h0, 1'b0);
        for (int i = 0; i < 5; i++) add(20'h10001, 1'b0, 20'h0, 20'h1, 20'h10001, 20'h0, 20'h0, 20'h0, 1'b0);
        add(20'h10001, 1'b0, 20'h0, 20'h1, 20'h00001, 20'h0, 20'h10000, 20'h0, 1'b0);
        add(20'h10001, 1'b0, 20'h0, 20'h1, 20'h00001, 20'h0, 20'h0, 20'h0, 1'b0);

        // Reset and settle
        rst = 1'b1;
        bus_if.raw_in    = IDLE;
        bus_if.clr_valid = 1'b0;
        bus_if.clr_mask  = 20'h0;
        bus_if.irq_en    = 20'h1;
        step(3);
        chk_all("reset", 20'h0, 20'h0, 20'h0, 20'h0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk_all($sformatf("settle%0d", i), 20'h0, 20'h0, 20'h0, 20'h0, 1'b0);
        end

        // Table-driven vectors, one clock edge per row
        for (int i = 0; i < vecs.size(); i++) begin
            bus_if.raw_in    = vecs[i].raw;
            bus_if.clr_valid = vecs[i].clrv;
            bus_if.clr_mask  = vecs[i].clrm;
            bus_if.irq_en    = vecs[i].en;
            step(1);
            chk_all($sformatf("row%0d", i), vecs[i].lvl, vecs[i].rise, vecs[i].fall, vecs[i].ev, vecs[i].irq);
        end

        // Set wins over a simultaneous clear on ch2
        bus_if.irq_en = 20'h4;
        bus_if.raw_in = 20'h10005;
        step(6);
        chk("sc press rise", bus_if.rise_pulse, 20'h4);
        step(1);
        chk("sc press event", bus_if.event_q, 20'h4);
        step(1);
        chk("sc press irq", {19'd0, bus_if.irq}, 20'h1);
        bus_if.raw_in = 20'h10001;
        step(6);
        chk("sc release fall", bus_if.fall_pulse, 20'h4);
        chk("sc release level", bus_if.level_out, 20'h1);
        bus_if.raw_in = 20'h10005;
        step(6);
        chk("sc repress rise", bus_if.rise_pulse, 20'h4);
        bus_if.clr_valid = 1'b1;
        bus_if.clr_mask  = 20'h4;
        step(1);
        chk("sc collide event", bus_if.event_q, 20'h4);
        chk("sc collide irq", {19'd0, bus_if.irq}, 20'h1);
        step(1);
        chk("sc clear event", bus_if.event_q, 20'h0);
        chk("sc clear irq", {19'd0, bus_if.irq}, 20'h1);
        bus_if.clr_valid = 1'b0;
        bus_if.clr_mask  = 20'h0;
        step(1);
        chk("sc irq fall", {19'd0, bus_if.irq}, 20'h0);

        // Reset in the middle of ch3's debounce
        bus_if.raw_in = 20'h1000D;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk($sformatf("mid%0d rise", i), bus_if.rise_pulse, 20'h0);
            chk($sformatf("mid%0d level", i), bus_if.level_out, 20'h5);
        end
        rst = 1'b1;
        step(1);
        chk_all("midrst", 20'h0, 20'h0, 20'h0, 20'h0, 1'b0);
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step(1);
            chk($sformatf("post%0d level", i), bus_if.level_out, 20'h0);
        end
        step(1);
        chk("post6 level", bus_if.level_out, 20'hD);
        chk("post6 rise", bus_if.rise_pulse, 20'hD);
        step(1);
        chk("post7 event", bus_if.event_q, 20'hD);
        step(1);
        chk("post8 irq", {19'd0, bus_if.irq}, 20'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
